decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 138 +++++++++++++
 tb/tb_decode.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Instruction decode stage: FETCH word handshake in, decoded fields out to EXECUTE, jump redirect back to FETCH.
// Optional immediate-operand collection is enabled by defining DECODE_IMM_EN.
`default_nettype none

module decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fe_valid_i,
  output logic        fe_ready_o,
  input  logic [15:0] fe_addr_i,
  input  logic [15:0] fe_inst_i,
  output logic        fe_valid_o,
  output logic [15:0] fe_pc_o,
  output logic        exe_valid_o,
  input  logic        exe_ready_i,
  output logic [15:0] exe_addr_o,
  output logic [3:0]  exe_opcode_o,
  output logic [3:0]  exe_src_reg_o,
  output logic [1:0]  exe_src_mode_o,
  output logic [3:0]  exe_dst_reg_o,
  output logic [1:0]  exe_dst_mode_o,
  output logic        exe_imm_valid_o,
  output logic [15:0] exe_imm_o,
  input  logic        exe_jmp_valid_i,
  input  logic [15:0] exe_jmp_pc_i
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1
`ifdef DECODE_IMM_EN
    ,WAIT_IMM = 2'd2
`endif
  } state_t;

  state_t state, state_nxt, head_nxt;
  logic   flush, accept, fire, load_inst;

  // While a redirect is requested or being announced, incoming words belong to the old stream.
  assign flush      = exe_jmp_valid_i || fe_valid_o;
  assign fe_ready_o = (state != FULL) || exe_ready_i || flush;
  assign accept     = fe_valid_i && fe_ready_o && !flush;
  assign fire       = exe_valid_o && exe_ready_i;

`ifdef DECODE_IMM_EN
  logic load_imm;
  assign head_nxt = (fe_inst_i[11:8] == 4'hF && fe_inst_i[7:6] == 2'd2) ? WAIT_IMM : FULL;
`else
  assign head_nxt = FULL;
`endif

  always_comb begin
    state_nxt = state;
    load_inst = 1'b0;
`ifdef DECODE_IMM_EN
    load_imm  = 1'b0;
`endif
    if (exe_jmp_valid_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_inst = 1'b1;
            state_nxt = head_nxt;
          end
        end
`ifdef DECODE_IMM_EN
        WAIT_IMM: begin
          if (accept) begin
            load_imm  = 1'b1;
            state_nxt = FULL;
          end
        end
`endif
        FULL: begin
          if (accept) begin
            load_inst = 1'b1;
            state_nxt = head_nxt;
          end else if (fire) begin
            state_nxt = EMPTY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= EMPTY;
      exe_valid_o    <= 1'b0;
      exe_addr_o     <= '0;
      exe_opcode_o   <= '0;
      exe_src_reg_o  <= '0;
      exe_src_mode_o <= '0;
      exe_dst_reg_o  <= '0;
      exe_dst_mode_o <= '0;
      fe_valid_o     <= 1'b1;
      fe_pc_o        <= RESET_PC;
    end else begin
      state       <= state_nxt;
      exe_valid_o <= (state_nxt == FULL);
      fe_valid_o  <= exe_jmp_valid_i;
      if (exe_jmp_valid_i) begin
        fe_pc_o <= exe_jmp_pc_i;
      end
      if (load_inst) begin
        exe_addr_o     <= fe_addr_i;
        exe_opcode_o   <= fe_inst_i[15:12];
        exe_src_reg_o  <= fe_inst_i[11:8];
        exe_src_mode_o <= fe_inst_i[7:6];
        exe_dst_reg_o  <= fe_inst_i[5:2];
        exe_dst_mode_o <= fe_inst_i[1:0];
      end
    end
  end

`ifdef DECODE_IMM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || load_inst) begin
      exe_imm_valid_o <= 1'b0;
      exe_imm_o       <= '0;
    end else if (load_imm) begin
      exe_imm_valid_o <= 1'b1;
      exe_imm_o       <= fe_inst_i;
    end
  end
`else
  assign exe_imm_valid_o = 1'b0;
  assign exe_imm_o       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// Scoreboard bench for decode: a stimulus process with a transaction-level model, and a negedge monitor.
`default_nettype none

module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_valid_i, fe_ready_o, fe_valid_o, exe_valid_o, exe_ready_i;
  logic [15:0] fe_addr_i, fe_inst_i, fe_pc_o, exe_addr_o, exe_imm_o, exe_jmp_pc_i;
  logic [3:0]  exe_opcode_o, exe_src_reg_o, exe_dst_reg_o;
  logic [1:0]  exe_src_mode_o, exe_dst_mode_o;
  logic        exe_imm_valid_o, exe_jmp_valid_i;

  decode #(.RESET_PC(16'h0000)) dut (
    .clk_i(clk), .rst_i(rst),
    .fe_valid_i(fe_valid_i), .fe_ready_o(fe_ready_o),
    .fe_addr_i(fe_addr_i), .fe_inst_i(fe_inst_i),
    .fe_valid_o(fe_valid_o), .fe_pc_o(fe_pc_o),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
    .exe_addr_o(exe_addr_o), .exe_opcode_o(exe_opcode_o),
    .exe_src_reg_o(exe_src_reg_o), .exe_src_mode_o(exe_src_mode_o),
    .exe_dst_reg_o(exe_dst_reg_o), .exe_dst_mode_o(exe_dst_mode_o),
    .exe_imm_valid_o(exe_imm_valid_o), .exe_imm_o(exe_imm_o),
    .exe_jmp_valid_i(exe_jmp_valid_i), .exe_jmp_pc_i(exe_jmp_pc_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] inst;
    logic [15:0] imm;
    bit          immv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Abstract view of the stage: an instruction offered to EXECUTE, a half-collected one, a pending redirect.
  bit          m_full, m_part, m_redir;
  logic [15:0] m_part_addr, m_part_inst, m_pc;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_imm_head(input logic [15:0] w);
`ifdef DECODE_IMM_EN
    return (w[11:8] == 4'hF) && (w[7:6] == 2'd2);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every EXECUTE handshake consumes the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst && exe_valid_o && exe_ready_i) begin
      if (q.size() == 0) begin
        chk("unexpected_instruction", exe_addr_o, 16'hxxxx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("exe_addr", exe_addr_o, e.addr);
        chk("exe_opcode", {12'd0, exe_opcode_o}, {12'd0, e.inst[15:12]});
        chk("exe_src_reg", {12'd0, exe_src_reg_o}, {12'd0, e.inst[11:8]});
        chk("exe_src_mode", {14'd0, exe_src_mode_o}, {14'd0, e.inst[7:6]});
        chk("exe_dst_reg", {12'd0, exe_dst_reg_o}, {12'd0, e.inst[5:2]});
        chk("exe_dst_mode", {14'd0, exe_dst_mode_o}, {14'd0, e.inst[1:0]});
        chk("exe_imm_valid", {15'd0, exe_imm_valid_o}, {15'd0, e.immv});
`ifdef DECODE_IMM_EN
        if (e.immv) chk("exe_imm", exe_imm_o, e.imm);
`else
        chk("exe_imm_zero", exe_imm_o, 16'h0000);
`endif
      end
    end
  end

  task automatic cycle(input bit fv, input logic [15:0] a, input logic [15:0] w,
                       input bit er, input bit jv, input logic [15:0] jpc);
    bit   ready, acc, fire;
    exp_t e;
    fe_valid_i = fv; fe_addr_i = a; fe_inst_i = w;
    exe_ready_i = er; exe_jmp_valid_i = jv; exe_jmp_pc_i = jpc;
    #1;
    ready = !m_full || er || jv || m_redir;
    chk("exe_valid", {15'd0, exe_valid_o}, {15'd0, m_full});
    chk("fe_valid", {15'd0, fe_valid_o}, {15'd0, m_redir});
    chk("fe_pc", fe_pc_o, m_pc);
    chk("fe_ready", {15'd0, fe_ready_o}, {15'd0, ready});
    acc  = fv && ready && !(jv || m_redir);
    fire = m_full && er;
    if (jv) begin
      if (m_full && !fire) void'(q.pop_back());
      m_full = 0; m_part = 0; m_pc = jpc;
    end else if (acc) begin
      if (m_part) begin
        e = '{m_part_addr, m_part_inst, w, 1'b1};
        q.push_back(e);
        m_part = 0; m_full = 1;
      end else if (is_imm_head(w)) begin
        m_part = 1; m_full = 0; m_part_addr = a; m_part_inst = w;
      end else begin
        e = '{a, w, 16'h0000, 1'b0};
        q.push_back(e);
        m_full = 1;
      end
    end else if (fire) begin
      m_full = 0;
    end
    m_redir = jv;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    fe_valid_i = 0; exe_ready_i = 0; exe_jmp_valid_i = 0;
    rst = 1;
    if (m_full) void'(q.pop_back());
    @(posedge clk); #1;
    chk("rst_fe_ready", {15'd0, fe_ready_o}, 16'd1);
    chk("rst_exe_valid", {15'd0, exe_valid_o}, 16'd0);
    chk("rst_imm_valid", {15'd0, exe_imm_valid_o}, 16'd0);
    chk("rst_exe_addr", exe_addr_o, 16'h0000);
    chk("rst_exe_fields", {exe_opcode_o, exe_src_reg_o, exe_src_mode_o, exe_dst_reg_o, exe_dst_mode_o}, 16'h0000);
    chk("rst_exe_imm", exe_imm_o, 16'h0000);
    @(posedge clk); #1;
    rst = 0;
    m_full = 0; m_part = 0; m_redir = 1; m_pc = 16'h0000;
  endtask

  initial begin
    logic [15:0] w;
    fe_addr_i = 0; fe_inst_i = 0; exe_jmp_pc_i = 0;
    m_full = 0; m_part = 0; m_redir = 0; m_pc = 0; m_part_addr = 0; m_part_inst = 0;
    @(posedge clk); #1;
    do_reset();
    // Redirect cycle after reset discards the offered word.
    cycle(1, 16'h0008, 16'h5555, 1, 0, 0);
    cycle(1, 16'h0010, 16'h1234, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Immediate pair.
    cycle(1, 16'h0020, 16'h0F80, 1, 0, 0);
    cycle(1, 16'h0022, 16'hBEEF, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Back-pressure for three cycles while the next word waits.
    cycle(1, 16'h0030, 16'h1234, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 16'h0032, 16'h6789, 0, 0, 0);
    cycle(1, 16'h0032, 16'h6789, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Redirect while collecting an immediate; words in the flush window are dropped.
    cycle(1, 16'h0040, 16'h0F80, 1, 0, 0);
    cycle(1, 16'h0042, 16'h1111, 1, 1, 16'h4000);
    cycle(1, 16'h0044, 16'h2222, 1, 0, 0);
    cycle(1, 16'h4000, 16'h3333, 1, 0, 0);
    // Back-to-back redirects, and redirect coinciding with a transfer.
    cycle(0, 0, 0, 1, 1, 16'h5000);
    cycle(1, 16'h5000, 16'h4444, 1, 1, 16'h6000);
    cycle(1, 16'h6000, 16'h7777, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 16'h7000);
    cycle(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      w = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        w[11:8] = 4'hF;
        w[7:6]  = 2'd2;
      end
      cycle(($urandom_range(0, 9) < 7), 16'($urandom), w,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), 16'($urandom));
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
